// File: rtl/task_ctrl_pkg.sv
// Shared types and constants for the task run controller and its answer mux.
// Trailer word 0 layout: {magic, task id, 8'h00, status}.
package task_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        WAIT_ANS,
        TRAILER
    } run_state_t;

    localparam logic [7:0] ST_OK         = 8'h00;
    localparam logic [7:0] ST_TIMEOUT    = 8'h01;
    localparam logic [7:0] ST_BAD_ID     = 8'h02;
    localparam logic [7:0] TRAILER_MAGIC = 8'hA5;

    localparam int CNT_W = 16;

    function automatic logic [31:0] trailer_w0(input logic [7:0] id, input logic [7:0] status);
        return {TRAILER_MAGIC, id, 8'h00, status};
    endfunction

endpackage

// File: rtl/task_run_controller_if.sv
// Command, input-gating, answer and TX signals between the run controller and its neighbours.
// master = controller side, slave = RX/TX framing plus the task wrapper bank.
interface task_run_controller_if #(
    parameter int NUM_TASKS = 8
);
    logic                        i_cmd_valid;
    logic [7:0]                  i_cmd_task_id;
    logic                        o_cmd_ready;

    logic                        i_in_valid;
    logic                        i_in_last;
    logic [NUM_TASKS-1:0]        o_task_valid;
    logic [NUM_TASKS-1:0]        o_task_sel;
    logic                        o_rst_dwc;
    logic [NUM_TASKS-1:0]        o_tv_in_last;

    logic [NUM_TASKS-1:0]        i_ans_valid;
    logic [NUM_TASKS-1:0]        i_ans_last;
    logic [NUM_TASKS-1:0][31:0]  i_ans_data;
    logic [NUM_TASKS-1:0][31:0]  i_ans_size;
    logic [NUM_TASKS-1:0][31:0]  i_ans_lat;

    logic                        o_tx_valid;
    logic [31:0]                 o_tx_data;
    logic                        o_tx_last;

    modport master (
        input  i_cmd_valid, i_cmd_task_id, i_in_valid, i_in_last,
               i_ans_valid, i_ans_last, i_ans_data, i_ans_size, i_ans_lat,
        output o_cmd_ready, o_task_valid, o_task_sel, o_rst_dwc, o_tv_in_last,
               o_tx_valid, o_tx_data, o_tx_last
    );

    modport slave (
        output i_cmd_valid, i_cmd_task_id, i_in_valid, i_in_last,
               i_ans_valid, i_ans_last, i_ans_data, i_ans_size, i_ans_lat,
        input  o_cmd_ready, o_task_valid, o_task_sel, o_rst_dwc, o_tv_in_last,
               o_tx_valid, o_tx_data, o_tx_last
    );

endinterface

// File: rtl/task_answer_mux.sv
// NUM_TASKS:1 answer select plus the registered TX stage (answer beats or trailer words), 1-cycle latency.
// No backpressure: the downstream FIFO always accepts; out-of-range ids select all-zero answers.
module task_answer_mux #(
    parameter int NUM_TASKS = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [7:0]                 i_id,
    input  logic                       i_ans_en,
    input  logic                       i_trl_en,
    input  logic [1:0]                 i_trl_idx,
    input  logic [31:0]                i_trl_w0,
    input  logic [NUM_TASKS-1:0]       i_ans_valid,
    input  logic [NUM_TASKS-1:0]       i_ans_last,
    input  logic [NUM_TASKS-1:0][31:0] i_ans_data,
    input  logic [NUM_TASKS-1:0][31:0] i_ans_size,
    input  logic [NUM_TASKS-1:0][31:0] i_ans_lat,
    output logic                       o_sel_valid,
    output logic                       o_sel_last,
    output logic                       o_tx_valid,
    output logic [31:0]                o_tx_data,
    output logic                       o_tx_last
);
    logic        w_vld;
    logic        w_last;
    logic [31:0] w_data;
    logic [31:0] w_size;
    logic [31:0] w_lat;
    logic [31:0] w_trl_data;

    logic        r_tx_valid;
    logic [31:0] r_tx_data;
    logic        r_tx_last;

    always_comb begin
        w_vld  = 1'b0;
        w_last = 1'b0;
        w_data = '0;
        w_size = '0;
        w_lat  = '0;
        for (int k = 0; k < NUM_TASKS; k++) begin
            if (i_id == 8'(k)) begin
                w_vld  = i_ans_valid[k];
                w_last = i_ans_last[k];
                w_data = i_ans_data[k];
                w_size = i_ans_size[k];
                w_lat  = i_ans_lat[k];
            end
        end
    end

    assign o_sel_valid = i_ans_en && w_vld;
    assign o_sel_last  = i_ans_en && w_vld && w_last;

    // Size and latency are taken live in the cycle their trailer word is produced.
    always_comb begin
        case (i_trl_idx)
            2'd0:    w_trl_data = i_trl_w0;
            2'd1:    w_trl_data = w_size;
            default: w_trl_data = w_lat;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_tx_last  <= 1'b0;
        end else if (i_trl_en) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_trl_data;
            r_tx_last  <= (i_trl_idx == 2'd2);
        end else begin
            r_tx_valid <= o_sel_valid;
            r_tx_data  <= o_sel_valid ? w_data : 32'h0;
            r_tx_last  <= 1'b0;
        end
    end

    assign o_tx_valid = r_tx_valid;
    assign o_tx_data  = r_tx_data;
    assign o_tx_last  = r_tx_last;

endmodule

// File: rtl/task_run_controller.sv
// Runs one test vector on a selected task wrapper: clear converter, gate input, forward answers, add trailer.
// Commands accepted only in IDLE; answers and TX have no backpressure; TX is 1 cycle behind the answer.
module task_run_controller
    import task_ctrl_pkg::*;
#(
    parameter int NUM_TASKS      = 8,
    parameter int CLR_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    task_run_controller_if.master  io_bus
);
    localparam logic [7:0]       NUM_ID   = 8'(NUM_TASKS);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    run_state_t           r_state;
    run_state_t           w_state_nxt;

    logic [7:0]           r_id;
    logic [7:0]           r_status;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_done;
    logic                 r_cmd_ready;
    logic [NUM_TASKS-1:0] r_sel;
    logic                 r_rst_dwc;
    logic [NUM_TASKS-1:0] r_tv_in_last;

    logic [7:0]           w_id_nxt;
    logic [7:0]           w_status_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_done_nxt;
    logic                 w_cmd_ready_nxt;
    logic [NUM_TASKS-1:0] w_sel_nxt;
    logic                 w_rst_dwc_nxt;
    logic [NUM_TASKS-1:0] w_tv_nxt;

    logic                 w_accept;
    logic                 w_cmd_id_ok;
    logic                 w_in_last_acc;
    logic                 w_sel_valid;
    logic                 w_sel_last;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic [NUM_TASKS-1:0] w_cmd_onehot;

    assign w_accept      = (r_state == IDLE) && r_cmd_ready && io_bus.i_cmd_valid;
    assign w_cmd_id_ok   = (io_bus.i_cmd_task_id < NUM_ID);
    assign w_in_last_acc = (r_state == LOAD) && io_bus.i_in_valid && io_bus.i_in_last;
    assign w_cnt_inc     = r_cnt + CNT_W'(1);

    always_comb begin
        for (int k = 0; k < NUM_TASKS; k++) begin
            w_cmd_onehot[k] = (io_bus.i_cmd_task_id == 8'(k));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Timeout fires when the incremented idle count reaches TIMEOUT_CYCLES-1, so the
    // first trailer word lands TIMEOUT_CYCLES cycles after the tv_in_last pulse.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:     if (w_accept) w_state_nxt = w_cmd_id_ok ? CLEAR : TRAILER;
            CLEAR:    if (r_cnt == CLR_LAST) w_state_nxt = LOAD;
            LOAD:     if (w_in_last_acc) w_state_nxt = (r_done || w_sel_last) ? TRAILER : WAIT_ANS;
            WAIT_ANS: if (w_sel_last || (!w_sel_valid && (w_cnt_inc == TMO_LAST))) w_state_nxt = TRAILER;
            TRAILER:  if (r_cnt == CNT_W'(2)) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_id_nxt        = r_id;
        w_status_nxt    = r_status;
        w_done_nxt      = r_done;
        w_sel_nxt       = r_sel;
        w_cnt_nxt       = '0;
        w_tv_nxt        = '0;
        // Ready rises one cycle after the trailer state ends, i.e. the cycle after w2 is on TX.
        w_cmd_ready_nxt = (r_state == IDLE) && (w_state_nxt == IDLE);
        w_rst_dwc_nxt   = (w_state_nxt == CLEAR);

        if (w_accept) begin
            w_id_nxt     = io_bus.i_cmd_task_id;
            w_status_nxt = w_cmd_id_ok ? ST_OK : ST_BAD_ID;
            w_done_nxt   = 1'b0;
            w_sel_nxt    = w_cmd_onehot;
        end
        if (w_state_nxt == IDLE) begin
            w_sel_nxt = '0;
        end
        if ((r_state == LOAD) && w_sel_last) begin
            w_done_nxt = 1'b1;
        end
        if (w_in_last_acc) begin
            w_tv_nxt = r_sel;
        end
        if ((r_state == WAIT_ANS) && (w_state_nxt == TRAILER) && !w_sel_last) begin
            w_status_nxt = ST_TIMEOUT;
        end

        if (w_state_nxt == r_state) begin
            case (r_state)
                CLEAR, TRAILER: w_cnt_nxt = w_cnt_inc;
                WAIT_ANS:       w_cnt_nxt = w_sel_valid ? '0 : w_cnt_inc;
                default:        w_cnt_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_id         <= '0;
            r_status     <= ST_OK;
            r_cnt        <= '0;
            r_done       <= 1'b0;
            r_cmd_ready  <= 1'b1;
            r_sel        <= '0;
            r_rst_dwc    <= 1'b0;
            r_tv_in_last <= '0;
        end else begin
            r_id         <= w_id_nxt;
            r_status     <= w_status_nxt;
            r_cnt        <= w_cnt_nxt;
            r_done       <= w_done_nxt;
            r_cmd_ready  <= w_cmd_ready_nxt;
            r_sel        <= w_sel_nxt;
            r_rst_dwc    <= w_rst_dwc_nxt;
            r_tv_in_last <= w_tv_nxt;
        end
    end

    task_answer_mux #(
        .NUM_TASKS (NUM_TASKS)
    ) u_answer_mux (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_id        (r_id),
        .i_ans_en    ((r_state == LOAD) || (r_state == WAIT_ANS)),
        .i_trl_en    (r_state == TRAILER),
        .i_trl_idx   (r_cnt[1:0]),
        .i_trl_w0    (trailer_w0(r_id, r_status)),
        .i_ans_valid (io_bus.i_ans_valid),
        .i_ans_last  (io_bus.i_ans_last),
        .i_ans_data  (io_bus.i_ans_data),
        .i_ans_size  (io_bus.i_ans_size),
        .i_ans_lat   (io_bus.i_ans_lat),
        .o_sel_valid (w_sel_valid),
        .o_sel_last  (w_sel_last),
        .o_tx_valid  (io_bus.o_tx_valid),
        .o_tx_data   (io_bus.o_tx_data),
        .o_tx_last   (io_bus.o_tx_last)
    );

    assign io_bus.o_cmd_ready  = r_cmd_ready;
    assign io_bus.o_task_sel   = r_sel;
    assign io_bus.o_rst_dwc    = r_rst_dwc;
    assign io_bus.o_tv_in_last = r_tv_in_last;
    assign io_bus.o_task_valid = ((r_state == LOAD) && io_bus.i_in_valid) ? r_sel : '0;

endmodule

// File: tb/tb_task_run_controller.sv
// Directed bench for task_run_controller: clear, load, answer forwarding, trailer, bad id, timeout, reset.
module tb_task_run_controller;
    localparam int NT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    task_run_controller_if #(.NUM_TASKS(NT)) bus ();

    task_run_controller #(
        .NUM_TASKS      (NT),
        .CLR_CYCLES     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [32:0] tx_q[$];
    int          txc_q[$];
    int          tv_cnt   = 0;
    int          tv_cyc   = -1;
    logic [7:0]  tv_bits  = '0;
    int          rdy_rise = -1;
    logic        rdy_prev = 1'b0;
    logic        sel_seen = 1'b0;
    logic        dwc_seen = 1'b0;
    logic        bad5     = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (bus.o_tx_valid) begin
            tx_q.push_back({bus.o_tx_last, bus.o_tx_data});
            txc_q.push_back(cyc);
            if (bus.o_tx_data[31:16] == 16'h5555) bad5 = 1'b1;
        end
        if (bus.o_tv_in_last != '0) begin
            tv_cnt  = tv_cnt + 1;
            tv_cyc  = cyc;
            tv_bits = bus.o_tv_in_last;
        end
        if (bus.o_cmd_ready && !rdy_prev) rdy_rise = cyc;
        rdy_prev = bus.o_cmd_ready;
        if (bus.o_task_sel != '0) sel_seen = 1'b1;
        if (bus.o_rst_dwc) dwc_seen = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        tx_q.delete();
        txc_q.delete();
        tv_cnt   = 0;
        sel_seen = 1'b0;
        dwc_seen = 1'b0;
        bad5     = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] id);
        for (int i = 0; i < 50 && !bus.o_cmd_ready; i++) step();
        bus.i_cmd_valid   = 1'b1;
        bus.i_cmd_task_id = id;
        step();
        bus.i_cmd_valid   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        checks++; if (bus.o_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", bus.o_cmd_ready); end
        checks++; if (bus.o_task_sel !== 8'h00) begin errors++; $display("FAIL reset_task_sel: got %h want 00", bus.o_task_sel); end
        checks++; if (bus.o_rst_dwc !== 1'b0) begin errors++; $display("FAIL reset_rst_dwc: got %b want 0", bus.o_rst_dwc); end
        checks++; if (bus.o_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", bus.o_tx_valid); end
        checks++; if (bus.o_tv_in_last !== 8'h00) begin errors++; $display("FAIL reset_tv_in_last: got %h want 00", bus.o_tv_in_last); end
        rst = 1'b0;
        step();
        checks++; if (bus.o_cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", bus.o_cmd_ready); end
    endtask

    task automatic test_clear();
        int n;
        clear_mon();
        send_cmd(8'd3);
        checks++; if (bus.o_cmd_ready !== 1'b0) begin errors++; $display("FAIL clear_ready_low: got %b want 0", bus.o_cmd_ready); end
        checks++; if (bus.o_task_sel !== 8'h08) begin errors++; $display("FAIL clear_task_sel: got %h want 08", bus.o_task_sel); end
        checks++; if (bus.o_rst_dwc !== 1'b1) begin errors++; $display("FAIL clear_rst_dwc_first: got %b want 1", bus.o_rst_dwc); end
        bus.i_in_valid = 1'b1;
        #1;
        checks++; if (bus.o_task_valid !== 8'h00) begin errors++; $display("FAIL clear_gates_input: got %h want 00", bus.o_task_valid); end
        bus.i_in_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.o_rst_dwc) n++;
            step();
        end
        checks++; if (n != 4) begin errors++; $display("FAIL clear_dwc_cycles: got %0d want 4", n); end
        checks++; if (bus.o_task_sel !== 8'h08) begin errors++; $display("FAIL load_task_sel: got %h want 08", bus.o_task_sel); end
    endtask

    task automatic test_answer();
        int c0;
        bus.i_ans_size[3] = 32'd8;
        bus.i_ans_lat[3]  = 32'h0000_0123;
        for (int b = 1; b <= 10; b++) begin
            bus.i_in_valid = 1'b1;
            bus.i_in_last  = (b == 10);
            #1;
            checks++; if (bus.o_task_valid !== 8'h08) begin errors++; $display("FAIL load_task_valid beat %0d: got %h want 08", b, bus.o_task_valid); end
            step();
        end
        bus.i_in_valid = 1'b0;
        bus.i_in_last  = 1'b0;
        checks++; if (bus.o_tv_in_last !== 8'h08) begin errors++; $display("FAIL tv_in_last_pulse: got %h want 08", bus.o_tv_in_last); end
        bus.i_ans_valid[3] = 1'b1;
        bus.i_ans_data[3]  = 32'h1111_0000;
        c0 = cyc;
        step();
        bus.i_ans_data[3]  = 32'h2222_0001;
        bus.i_ans_last[3]  = 1'b1;
        step();
        bus.i_ans_valid[3] = 1'b0;
        bus.i_ans_last[3]  = 1'b0;
        for (int i = 0; i < 20 && tx_q.size() < 5; i++) step();
        repeat (3) step();
        checks++; if (tx_q.size() != 5) begin errors++; $display("FAIL ans_word_count: got %0d want 5", tx_q.size()); end
        if (tx_q.size() == 5) begin
            checks++; if (tx_q[0] !== {1'b0, 32'h1111_0000}) begin errors++; $display("FAIL ans_data0: got %h want 011110000", tx_q[0]); end
            checks++; if (tx_q[1] !== {1'b0, 32'h2222_0001}) begin errors++; $display("FAIL ans_data1: got %h want 022220001", tx_q[1]); end
            checks++; if (tx_q[2] !== {1'b0, 32'hA503_0000}) begin errors++; $display("FAIL ans_w0: got %h want 0a5030000", tx_q[2]); end
            checks++; if (tx_q[3] !== {1'b0, 32'd8}) begin errors++; $display("FAIL ans_w1_size: got %h want 000000008", tx_q[3]); end
            checks++; if (tx_q[4] !== {1'b1, 32'h0000_0123}) begin errors++; $display("FAIL ans_w2_lat: got %h want 100000123", tx_q[4]); end
            checks++; if (txc_q[0] != c0 + 1) begin errors++; $display("FAIL ans_latency: got cycle %0d want %0d", txc_q[0], c0 + 1); end
            checks++; if (txc_q[2] != txc_q[1] + 1) begin errors++; $display("FAIL ans_w0_follows: got cycle %0d want %0d", txc_q[2], txc_q[1] + 1); end
            checks++; if (txc_q[4] != txc_q[2] + 2) begin errors++; $display("FAIL ans_trailer_contiguous: got cycle %0d want %0d", txc_q[4], txc_q[2] + 2); end
            checks++; if (rdy_rise != txc_q[4] + 1) begin errors++; $display("FAIL ans_ready_after_w2: got cycle %0d want %0d", rdy_rise, txc_q[4] + 1); end
        end
        checks++; if (tv_cnt != 1) begin errors++; $display("FAIL ans_tv_pulse_count: got %0d want 1", tv_cnt); end
    endtask

    task automatic test_bad_id();
        clear_mon();
        send_cmd(8'd9);
        for (int i = 0; i < 20 && tx_q.size() < 3; i++) step();
        repeat (3) step();
        checks++; if (tx_q.size() != 3) begin errors++; $display("FAIL bad_word_count: got %0d want 3", tx_q.size()); end
        if (tx_q.size() == 3) begin
            checks++; if (tx_q[0] !== {1'b0, 32'hA509_0002}) begin errors++; $display("FAIL bad_w0: got %h want 0a5090002", tx_q[0]); end
            checks++; if (tx_q[1] !== {1'b0, 32'h0}) begin errors++; $display("FAIL bad_w1: got %h want 000000000", tx_q[1]); end
            checks++; if (tx_q[2] !== {1'b1, 32'h0}) begin errors++; $display("FAIL bad_w2: got %h want 100000000", tx_q[2]); end
            checks++; if (txc_q[2] != txc_q[0] + 2) begin errors++; $display("FAIL bad_contiguous: got cycle %0d want %0d", txc_q[2], txc_q[0] + 2); end
        end
        checks++; if (sel_seen !== 1'b0) begin errors++; $display("FAIL bad_task_sel_seen: got %b want 0", sel_seen); end
        checks++; if (dwc_seen !== 1'b0) begin errors++; $display("FAIL bad_rst_dwc_seen: got %b want 0", dwc_seen); end
    endtask

    task automatic test_timeout();
        clear_mon();
        send_cmd(8'd2);
        repeat (6) step();
        bus.i_in_valid = 1'b1;
        bus.i_in_last  = 1'b1;
        step();
        bus.i_in_valid = 1'b0;
        bus.i_in_last  = 1'b0;
        for (int i = 0; i < 40 && tx_q.size() < 3; i++) step();
        repeat (3) step();
        checks++; if (tx_q.size() != 3) begin errors++; $display("FAIL tmo_word_count: got %0d want 3", tx_q.size()); end
        if (tx_q.size() == 3) begin
            checks++; if (tx_q[0] !== {1'b0, 32'hA502_0001}) begin errors++; $display("FAIL tmo_w0: got %h want 0a5020001", tx_q[0]); end
            checks++; if (txc_q[0] != tv_cyc + 16) begin errors++; $display("FAIL tmo_delay: got cycle %0d want %0d", txc_q[0], tv_cyc + 16); end
            checks++; if (tx_q[1] !== {1'b0, 32'd102}) begin errors++; $display("FAIL tmo_w1: got %h want 000000066", tx_q[1]); end
            checks++; if (tx_q[2] !== {1'b1, 32'h0000_0202}) begin errors++; $display("FAIL tmo_w2: got %h want 100000202", tx_q[2]); end
        end
        checks++; if (tv_bits !== 8'h04) begin errors++; $display("FAIL tmo_tv_bits: got %h want 04", tv_bits); end
    endtask

    task automatic test_same_cycle();
        int c0;
        clear_mon();
        send_cmd(8'd1);
        repeat (6) step();
        bus.i_in_valid     = 1'b1;
        bus.i_in_last      = 1'b1;
        bus.i_ans_valid[1] = 1'b1;
        bus.i_ans_last[1]  = 1'b1;
        bus.i_ans_data[1]  = 32'hDEAD_0001;
        c0 = cyc;
        step();
        bus.i_in_valid     = 1'b0;
        bus.i_in_last      = 1'b0;
        bus.i_ans_valid[1] = 1'b0;
        bus.i_ans_last[1]  = 1'b0;
        for (int i = 0; i < 20 && tx_q.size() < 4; i++) step();
        repeat (3) step();
        checks++; if (tx_q.size() != 4) begin errors++; $display("FAIL same_word_count: got %0d want 4", tx_q.size()); end
        if (tx_q.size() == 4) begin
            checks++; if (tx_q[0] !== {1'b0, 32'hDEAD_0001}) begin errors++; $display("FAIL same_data: got %h want 0dead0001", tx_q[0]); end
            checks++; if (txc_q[0] != c0 + 1) begin errors++; $display("FAIL same_data_cycle: got %0d want %0d", txc_q[0], c0 + 1); end
            checks++; if (tx_q[1] !== {1'b0, 32'hA501_0000}) begin errors++; $display("FAIL same_w0: got %h want 0a5010000", tx_q[1]); end
            checks++; if (txc_q[1] != c0 + 2) begin errors++; $display("FAIL same_w0_cycle: got %0d want %0d", txc_q[1], c0 + 2); end
            checks++; if (tx_q[3] !== {1'b1, 32'h0000_0201}) begin errors++; $display("FAIL same_w2: got %h want 100000201", tx_q[3]); end
        end
        checks++; if (tv_cnt != 1 || tv_cyc != c0 + 1) begin errors++; $display("FAIL same_tv_pulse: got count %0d cycle %0d want 1 at %0d", tv_cnt, tv_cyc, c0 + 1); end
        checks++; if (bus.o_cmd_ready !== 1'b1) begin errors++; $display("FAIL same_back_to_idle: got %b want 1", bus.o_cmd_ready); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        bus.i_ans_data[5]  = 32'h5555_0000;
        bus.i_ans_valid[5] = 1'b1;
        send_cmd(8'd3);
        repeat (6) step();
        bus.i_in_valid = 1'b1;
        bus.i_in_last  = 1'b1;
        step();
        bus.i_in_valid = 1'b0;
        bus.i_in_last  = 1'b0;
        bus.i_ans_last[5] = 1'b1;
        step();
        bus.i_ans_last[5] = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        checks++; if (bus.o_tx_valid !== 1'b0) begin errors++; $display("FAIL rmid_tx_valid: got %b want 0", bus.o_tx_valid); end
        checks++; if (bus.o_task_sel !== 8'h00) begin errors++; $display("FAIL rmid_task_sel: got %h want 00", bus.o_task_sel); end
        checks++; if (bus.o_rst_dwc !== 1'b0) begin errors++; $display("FAIL rmid_rst_dwc: got %b want 0", bus.o_rst_dwc); end
        checks++; if (bus.o_cmd_ready !== 1'b1) begin errors++; $display("FAIL rmid_cmd_ready: got %b want 1", bus.o_cmd_ready); end
        rst = 1'b0;
        bus.i_ans_valid[5] = 1'b0;
        repeat (25) step();
        checks++; if (tx_q.size() != 0) begin errors++; $display("FAIL rmid_no_trailer: got %0d words want 0", tx_q.size()); end
        checks++; if (bad5 !== 1'b0) begin errors++; $display("FAIL rmid_task5_leak: got %b want 0", bad5); end
        checks++; if (tv_cnt != 1) begin errors++; $display("FAIL rmid_tv_pulse_count: got %0d want 1", tv_cnt); end
    endtask

    initial begin
        bus.i_cmd_valid   = 1'b0;
        bus.i_cmd_task_id = '0;
        bus.i_in_valid    = 1'b0;
        bus.i_in_last     = 1'b0;
        bus.i_ans_valid   = '0;
        bus.i_ans_last    = '0;
        for (int k = 0; k < NT; k++) begin
            bus.i_ans_data[k] = '0;
            bus.i_ans_size[k] = 32'd100 + 32'(k);
            bus.i_ans_lat[k]  = 32'h0000_0200 + 32'(k);
        end
        #1;
        test_reset();
        test_clear();
        test_answer();
        test_bad_id();
        test_timeout();
        test_same_cycle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
